// File: rtl/lbp_scheduler_if.sv
// Signal bundle between lbp_scheduler and its gray-image memory, LBP datapath and result memory.
// Handshake: a window transfers on the rising edge where win_valid && win_ready; win_valid stays high
// and win_pix/win_addr stay stable until that edge. gray_req and res_valid/lbp_valid are single-cycle strobes.
interface lbp_scheduler_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic            gray_ready;
  logic            gray_req;
  logic [AW-1:0]   gray_addr;
  logic [DW-1:0]   gray_data;
  logic            win_valid;
  logic            win_ready;
  logic [9*DW-1:0] win_pix;
  logic [AW-1:0]   win_addr;
  logic            res_valid;
  logic [DW-1:0]   res_data;
  logic            lbp_valid;
  logic [AW-1:0]   lbp_addr;
  logic [DW-1:0]   lbp_data;

  modport master (
    input  gray_ready, gray_data, win_ready, res_valid, res_data,
    output gray_req, gray_addr, win_valid, win_pix, win_addr, lbp_valid, lbp_addr, lbp_data
  );

  modport slave (
    output gray_ready, gray_data, win_ready, res_valid, res_data,
    input  gray_req, gray_addr, win_valid, win_pix, win_addr, lbp_valid, lbp_addr, lbp_data
  );
endinterface

// File: rtl/lbp_scheduler.sv
// Raster-scan sequencer: fetches 3x3 windows with column reuse, hands them to the LBP datapath,
// and writes each returned code to the result memory at the window centre address.
module lbp_scheduler #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  lbp_scheduler_if.master bus,
  output logic            finish,
  output logic [2:0]      state_dbg
);
  localparam int XB = $clog2(IMG_W);
  localparam int PW = 9 * DW;
  localparam int KB = $clog2(PW);
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 2);
  localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 2);

  typedef enum logic [2:0] {IDLE, FILL, SLIDE, ISSUE, WAIT_RES, WRITE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] x, y;
  logic [1:0]    r_idx, c_idx;
  logic [PW-1:0] win;
  logic [AW-1:0] fetch_row, fetch_col, centre;
  logic [3:0]    cap_k;
  logic [KB-1:0] cap_lsb;

  // Fetch address tracks the current fetch index; it holds while gray_ready is low.
  always_comb begin
    fetch_row = y + AW'(r_idx) - AW'(1);
    if (state == SLIDE) begin
      fetch_col = x + AW'(1);
      cap_k     = {2'b00, r_idx} * 4'd3 + 4'd2;
    end else begin
      fetch_col = x + AW'(c_idx) - AW'(1);
      cap_k     = {2'b00, r_idx} * 4'd3 + {2'b00, c_idx};
    end
    cap_lsb = KB'(int'(cap_k) * DW);
    centre  = (y << XB) + x;
  end

  assign bus.gray_req  = ((state == FILL) || (state == SLIDE)) && bus.gray_ready;
  assign bus.gray_addr = (fetch_row << XB) + fetch_col;
  assign bus.win_pix   = win;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      x             <= AW'(1);
      y             <= AW'(1);
      r_idx         <= 2'd0;
      c_idx         <= 2'd0;
      win           <= '0;
      bus.win_valid <= 1'b0;
      bus.win_addr  <= '0;
      bus.lbp_valid <= 1'b0;
      bus.lbp_addr  <= '0;
      bus.lbp_data  <= '0;
      finish        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.gray_ready) state <= FILL;
        FILL: if (bus.gray_ready) begin
          win[cap_lsb +: DW] <= bus.gray_data;
          if (r_idx == 2'd2) begin
            r_idx <= 2'd0;
            if (c_idx == 2'd2) begin
              c_idx         <= 2'd0;
              state         <= ISSUE;
              bus.win_valid <= 1'b1;
              bus.win_addr  <= centre;
            end else begin
              c_idx <= c_idx + 2'd1;
            end
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        SLIDE: if (bus.gray_ready) begin
          win[cap_lsb +: DW] <= bus.gray_data;
          if (r_idx == 2'd2) begin
            r_idx         <= 2'd0;
            state         <= ISSUE;
            bus.win_valid <= 1'b1;
            bus.win_addr  <= centre;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        ISSUE: if (bus.win_ready) begin
          bus.win_valid <= 1'b0;
          state         <= WAIT_RES;
        end
        WAIT_RES: if (bus.res_valid) begin
          bus.lbp_data  <= bus.res_data;
          bus.lbp_addr  <= bus.win_addr;
          bus.lbp_valid <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          bus.lbp_valid <= 1'b0;
          if (x < X_LAST) begin
            x     <= x + AW'(1);
            state <= SLIDE;
            // Reuse the two right-hand columns; SLIDE refills column 2.
            for (int r = 0; r < 3; r++) begin
              win[(3*r)*DW +: DW]   <= win[(3*r+1)*DW +: DW];
              win[(3*r+1)*DW +: DW] <= win[(3*r+2)*DW +: DW];
            end
          end else if (y < Y_LAST) begin
            x     <= AW'(1);
            y     <= y + AW'(1);
            state <= FILL;
          end else begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbp_scheduler.sv
// Bench for lbp_scheduler: directed fetch/handshake checks on a 128x128 instance and
// randomized full-frame runs on a 16x16 instance against a golden LBP image.
module tb_lbp_scheduler;
  localparam int BW = 128, BH = 128, BAW = 14;
  localparam int SW = 16, SH = 16, SAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big, rst_small, fin_big, fin_small;
  logic [2:0] st_big, st_small;
  lbp_scheduler_if #(.AW(BAW), .DW(8)) bb ();
  lbp_scheduler_if #(.AW(SAW), .DW(8)) sb ();

  lbp_scheduler #(.IMG_W(BW), .IMG_H(BH), .AW(BAW), .DW(8)) dut_big (
    .clk(clk), .reset(rst_big), .bus(bb.master), .finish(fin_big), .state_dbg(st_big));
  lbp_scheduler #(.IMG_W(SW), .IMG_H(SH), .AW(SAW), .DW(8)) dut_small (
    .clk(clk), .reset(rst_small), .bus(sb.master), .finish(fin_small), .state_dbg(st_small));

  logic [7:0] img_big [BW*BH];
  logic [7:0] img_small [SW*SH];
  logic [SAW+7:0] exp_q[$];
  int n_chk = 0, n_pass = 0;

  assign bb.gray_data = img_big[bb.gray_addr];
  assign sb.gray_data = img_small[sb.gray_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] big_window(input int y, input int x);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = img_big[(y-1+r)*BW + (x-1+c)];
    return w;
  endfunction

  function automatic logic [71:0] small_window(input int y, input int x);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = img_small[(y-1+r)*SW + (x-1+c)];
    return w;
  endfunction

  // Datapath function: one bit per neighbour, set when neighbour >= centre.
  function automatic logic [7:0] lbp_code(input logic [71:0] w);
    logic [7:0] code;
    code = 8'h00;
    for (int k = 0; k < 9; k++)
      if (k != 4) code = {code[6:0], (w[k*8 +: 8] >= w[32 +: 8])};
    return code;
  endfunction

  // One full pixel on the big instance starting in the first fetch cycle.
  task automatic big_pixel(input int y, input int x, input bit fill, input bit stall, input logic [7:0] rd);
    int n, r, col;
    logic [13:0] exp_a;
    logic [71:0] exp_w, held;
    n = fill ? 9 : 3;
    for (int i = 0; i < n; i++) begin
      r = fill ? i % 3 : i;
      col = fill ? x - 1 + i / 3 : x + 1;
      exp_a = 14'((y - 1 + r) * BW + col);
      if (stall && i == 4) begin
        bb.gray_ready = 1'b0;
        repeat (4) begin
          #1;
          n_chk++;
          if (bb.gray_req !== 1'b0 || bb.gray_addr !== exp_a)
            $display("FAIL fetch_stall y%0d x%0d: req=%0b addr=%0d, expected req=0 addr=%0d", y, x, bb.gray_req, bb.gray_addr, exp_a);
          else n_pass++;
          tick;
        end
        bb.gray_ready = 1'b1;
        #1;
      end
      n_chk++;
      if (bb.gray_req !== 1'b1 || bb.gray_addr !== exp_a)
        $display("FAIL fetch y%0d x%0d i%0d: req=%0b addr=%0d, expected req=1 addr=%0d", y, x, i, bb.gray_req, bb.gray_addr, exp_a);
      else n_pass++;
      tick;
    end
    exp_w = big_window(y, x);
    n_chk++;
    if (bb.win_valid !== 1'b1) $display("FAIL win_valid y%0d x%0d: got %0b expected 1", y, x, bb.win_valid);
    else n_pass++;
    n_chk++;
    if (bb.win_addr !== 14'(y * BW + x)) $display("FAIL win_addr y%0d x%0d: got %0d expected %0d", y, x, bb.win_addr, y * BW + x);
    else n_pass++;
    n_chk++;
    if (bb.win_pix !== exp_w) $display("FAIL win_pix y%0d x%0d: got %h expected %h", y, x, bb.win_pix, exp_w);
    else n_pass++;
    if (stall) begin
      bb.res_valid = 1'b1;
      bb.res_data = ~rd;
      held = exp_w;
      repeat (5) begin
        tick;
        bb.res_valid = 1'b0;
        n_chk++;
        if (bb.win_valid !== 1'b1 || bb.win_pix !== held || bb.lbp_valid !== 1'b0)
          $display("FAIL issue_hold y%0d x%0d: valid=%0b lbp_valid=%0b pix=%h, expected valid=1 lbp_valid=0 pix=%h", y, x, bb.win_valid, bb.lbp_valid, bb.win_pix, held);
        else n_pass++;
      end
    end
    bb.win_ready = 1'b1;
    tick;
    bb.win_ready = 1'b0;
    n_chk++;
    if (bb.win_valid !== 1'b0) $display("FAIL win_drop y%0d x%0d: got %0b expected 0", y, x, bb.win_valid);
    else n_pass++;
    if (stall) repeat (2) tick;
    bb.res_valid = 1'b1;
    bb.res_data = rd;
    tick;
    bb.res_valid = 1'b0;
    n_chk++;
    if (bb.lbp_valid !== 1'b1 || bb.lbp_addr !== 14'(y * BW + x) || bb.lbp_data !== rd)
      $display("FAIL lbp_write y%0d x%0d: valid=%0b addr=%0d data=%h, expected 1 %0d %h", y, x, bb.lbp_valid, bb.lbp_addr, bb.lbp_data, y * BW + x, rd);
    else n_pass++;
    tick;
    n_chk++;
    if (bb.lbp_valid !== 1'b0) $display("FAIL lbp_pulse y%0d x%0d: got %0b expected 0", y, x, bb.lbp_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    bb.gray_ready = 1'b0; bb.win_ready = 1'b0; bb.res_valid = 1'b0; bb.res_data = 8'h00;
    repeat (3) tick;
    rst_big = 1'b1;
    #1;
    n_chk++;
    if ({bb.gray_req, bb.win_valid, bb.lbp_valid, fin_big} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {bb.gray_req, bb.win_valid, bb.lbp_valid, fin_big});
    else n_pass++;
    n_chk++;
    if (bb.gray_addr !== 14'd0 || bb.win_addr !== 14'd0 || bb.lbp_addr !== 14'd0)
      $display("FAIL reset_addrs: got %0d %0d %0d expected 0 0 0", bb.gray_addr, bb.win_addr, bb.lbp_addr);
    else n_pass++;
    n_chk++;
    if (bb.win_pix !== 72'd0 || bb.lbp_data !== 8'd0)
      $display("FAIL reset_data: got pix=%h lbp_data=%h expected 0", bb.win_pix, bb.lbp_data);
    else n_pass++;
    repeat (3) begin
      tick;
      n_chk++;
      if (bb.gray_req !== 1'b0) $display("FAIL idle_no_req: got %0b expected 0", bb.gray_req);
      else n_pass++;
    end
    bb.gray_ready = 1'b1;
    #1;
    n_chk++;
    if (bb.gray_req !== 1'b0) $display("FAIL idle_ready_same_cycle: got %0b expected 0", bb.gray_req);
    else n_pass++;
    tick;
    n_chk++;
    if (bb.gray_req !== 1'b1) $display("FAIL first_req: got %0b expected 1", bb.gray_req);
    else n_pass++;
  endtask

  task automatic test_first_window;
    big_pixel(1, 1, 1'b1, 1'b0, 8'h5A);
  endtask

  task automatic test_slide;
    big_pixel(1, 2, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic test_row_wrap_and_stalls;
    for (int x = 3; x <= BW - 2; x++) big_pixel(1, x, 1'b0, 1'b0, 8'($urandom));
    big_pixel(2, 1, 1'b1, 1'b1, 8'($urandom));
  endtask

  task automatic test_big_restart;
    tick;
    rst_big = 1'b0;
    #1;
    n_chk++;
    if ({bb.gray_req, bb.win_valid, bb.lbp_valid, fin_big} !== 4'b0000 || bb.gray_addr !== 14'd0 || bb.lbp_addr !== 14'd0)
      $display("FAIL big_midreset: strobes=%b gray_addr=%0d lbp_addr=%0d expected 0", {bb.gray_req, bb.win_valid, bb.lbp_valid, fin_big}, bb.gray_addr, bb.lbp_addr);
    else n_pass++;
    tick;
    rst_big = 1'b1;
    tick;
    big_pixel(1, 1, 1'b1, 1'b0, 8'hC3);
  endtask

  // Randomized handshakes and a datapath model; stop_after>0 aborts after that many writes.
  task automatic run_small_frame(input int stop_after);
    logic [SAW+7:0] e;
    logic [7:0] code;
    logic [SAW-1:0] last_addr;
    int writes, cyc, cnt;
    bit pending, done, prev_lbp, quiet;
    exp_q.delete();
    for (int y = 1; y <= SH - 2; y++)
      for (int x = 1; x <= SW - 2; x++)
        exp_q.push_back({SAW'(y * SW + x), lbp_code(small_window(y, x))});
    writes = 0; cyc = 0; cnt = 0; code = 8'h00; last_addr = '0;
    pending = 1'b0; done = 1'b0; prev_lbp = 1'b0;
    while (!done && cyc < 20000) begin
      if (sb.lbp_valid) begin
        writes++;
        last_addr = sb.lbp_addr;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL extra_write: addr=%0d data=%h expected no write", sb.lbp_addr, sb.lbp_data);
        else begin
          e = exp_q.pop_front();
          if ({sb.lbp_addr, sb.lbp_data} !== e)
            $display("FAIL frame_write %0d: addr=%0d data=%h expected addr=%0d data=%h", writes, sb.lbp_addr, sb.lbp_data, e[SAW+7:8], e[7:0]);
          else n_pass++;
        end
        if (stop_after > 0 && writes >= stop_after) done = 1'b1;
      end
      if (fin_small) begin
        n_chk++;
        if (!prev_lbp) $display("FAIL finish_timing: finish rose without lbp_valid the cycle before, writes=%0d", writes);
        else n_pass++;
        done = 1'b1;
      end
      prev_lbp = sb.lbp_valid;
      if (pending) begin
        if (cnt == 0) begin
          sb.res_valid = 1'b1; sb.res_data = code; pending = 1'b0;
        end else begin
          cnt--; sb.res_valid = 1'b0;
        end
      end else begin
        sb.res_valid = ($urandom_range(0, 7) == 0);
        sb.res_data = 8'($urandom);
      end
      sb.win_ready = ($urandom_range(0, 2) != 0);
      if (sb.win_valid && sb.win_ready) begin
        code = lbp_code(sb.win_pix);
        pending = 1'b1;
        cnt = $urandom_range(0, 2);
      end
      sb.gray_ready = ($urandom_range(0, 3) != 0);
      tick;
      cyc++;
    end
    sb.res_valid = 1'b0;
    sb.win_ready = 1'b0;
    if (stop_after == 0) begin
      n_chk++;
      if (fin_small !== 1'b1) $display("FAIL frame_timeout: finish=%0b after %0d cycles, expected 1", fin_small, cyc);
      else n_pass++;
      n_chk++;
      if (writes != (SW - 2) * (SH - 2)) $display("FAIL write_count: got %0d expected %0d", writes, (SW - 2) * (SH - 2));
      else n_pass++;
      n_chk++;
      if (last_addr !== SAW'((SH - 2) * SW + SW - 2)) $display("FAIL last_addr: got %0d expected %0d", last_addr, (SH - 2) * SW + SW - 2);
      else n_pass++;
      quiet = 1'b1;
      sb.gray_ready = 1'b1;
      repeat (20) begin
        if (sb.gray_req || sb.lbp_valid || sb.win_valid || !fin_small) quiet = 1'b0;
        tick;
      end
      n_chk++;
      if (!quiet) $display("FAIL done_quiet: activity or finish drop after frame end, expected none");
      else n_pass++;
    end
  endtask

  task automatic test_full_frame;
    sb.gray_ready = 1'b0; sb.win_ready = 1'b0; sb.res_valid = 1'b0; sb.res_data = 8'h00;
    rst_small = 1'b1;
    run_small_frame(0);
  endtask

  task automatic test_midframe_rerun;
    rst_small = 1'b0;
    #1;
    n_chk++;
    if (fin_small !== 1'b0 || sb.lbp_valid !== 1'b0) $display("FAIL done_reset: finish=%0b lbp_valid=%0b expected 0 0", fin_small, sb.lbp_valid);
    else n_pass++;
    tick;
    rst_small = 1'b1;
    run_small_frame(60);
    rst_small = 1'b0;
    #1;
    n_chk++;
    if ({sb.gray_req, sb.win_valid, sb.lbp_valid, fin_small} !== 4'b0000 || sb.win_pix !== 72'd0 ||
        sb.win_addr !== 8'd0 || sb.lbp_addr !== 8'd0 || sb.lbp_data !== 8'd0 || sb.gray_addr !== 8'd0)
      $display("FAIL small_midreset: strobes=%b pix=%h win_addr=%0d lbp_addr=%0d lbp_data=%h expected all 0",
               {sb.gray_req, sb.win_valid, sb.lbp_valid, fin_small}, sb.win_pix, sb.win_addr, sb.lbp_addr, sb.lbp_data);
    else n_pass++;
    tick;
    rst_small = 1'b1;
    run_small_frame(0);
  endtask

  initial begin
    rst_big = 1'b0;
    rst_small = 1'b0;
    bb.gray_ready = 1'b0; bb.win_ready = 1'b0; bb.res_valid = 1'b0; bb.res_data = 8'h00;
    sb.gray_ready = 1'b0; sb.win_ready = 1'b0; sb.res_valid = 1'b0; sb.res_data = 8'h00;
    for (int i = 0; i < BW * BH; i++) img_big[i] = 8'($urandom);
    // Narrow value range so neighbour == centre ties occur often.
    for (int i = 0; i < SW * SH; i++) img_small[i] = 8'($urandom_range(0, 15));
    #1;
    test_reset;
    test_first_window;
    test_slide;
    test_row_wrap_and_stalls;
    test_big_restart;
    test_full_frame;
    test_midframe_rerun;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lbp_scheduler.md
# lbp_scheduler

Sequencer between the 128x128 gray-image memory port and the LBP compute datapath. Raster-scans all interior pixels, fetches each 3x3 neighbourhood with column reuse (9 reads at row start, 3 per subsequent pixel), and presents the window to the datapath over a valid/ready handshake. It then captures the datapath result, writes it to the LBP result memory, and raises `finish` after the last interior pixel. Border pixels are never written; the result memory initialises them to 0.

## Interface
- `IMG_W`, 128, image width in pixels (power of two)
- `IMG_H`, 128, image height in pixels
- `AW`, 14, address width (log2(IMG_W*IMG_H))
- `DW`, 8, pixel/result width
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `gray_ready`  in  1  image memory available; fetches only in cycles where high
- `gray_req`  out  1  read request; data returned in same cycle
- `gray_addr`  out  AW  read address, row*IMG_W+col
- `gray_data`  in  DW  read data, sampled at rising edge ending a `gray_req` cycle
- `win_valid`  out  1  window presented to datapath
- `win_ready`  in  1  datapath accepts window
- `win_pix`  out  9*DW  window; pixel k=r*3+c at bits [8k+7:8k]; r,c=0..2, centre k=4
- `win_addr`  out  AW  centre address of presented window
- `res_valid`  in  1  datapath result valid (single-cycle pulse)
- `res_data`  in  DW  datapath LBP code
- `lbp_valid`  out  1  result write strobe, one cycle per pixel
- `lbp_addr`  out  AW  result write address (= centre address)
- `lbp_data`  out  DW  result write data
- `finish`  out  1  frame complete, held until reset

## Operation
- Centre (y,x) scans y=1..IMG_H-2 outer, x=1..IMG_W-2 inner; addr=y*IMG_W+x.
- States: IDLE, FILL, SLIDE, ISSUE, WAIT_RES, WRITE, DONE.
- IDLE: y=1,x=1; -> FILL on first cycle with `gray_ready`=1.
- FILL: 9 reads, column-major: c=0..2 outer, r=0..2 inner; addr=(y-1+r)*IMG_W+(x-1+c); data into w[r][c]. After 9th -> ISSUE.
- SLIDE: columns shift left (w[r][0]<=w[r][1], w[r][1]<=w[r][2]); 3 reads r=0..2 at (y-1+r)*IMG_W+(x+1) into w[r][2]. After 3rd -> ISSUE.
- ISSUE: `win_valid`=1, `win_pix`/`win_addr` stable; on `win_ready` -> WAIT_RES.
- WAIT_RES: on `res_valid`, register `res_data` and addr -> WRITE. `res_valid` in any other state is ignored.
- WRITE: `lbp_valid`=1 one cycle. Then: x<IMG_W-2 -> x++, SLIDE; else y<IMG_H-2 -> x=1, y++, FILL; else -> DONE.
- DONE: `finish`=1, no further reads/writes; stays until reset.
- Fetch stall: in FILL/SLIDE, `gray_req`=`gray_ready`; when `gray_ready`=0, fetch index and `gray_addr` hold, no data captured.
- Address arithmetic AW bits, no overflow for interior scan; 126x126=15876 writes for default size.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; `gray_req`, `win_valid`, `lbp_valid`, `finish`=0; `gray_addr`, `win_addr`, `lbp_addr`, `lbp_data`, `win_pix`=0.
- Read latency 0: `gray_data` valid in the `gray_req` cycle, captured at its closing edge.
- `win_valid` rises the cycle after the last fetch; handshake completes on edge where `win_valid`&`win_ready`.
- `res_valid` earliest one cycle after handshake; `lbp_valid` the cycle after `res_valid`.
- Steady-state minimum per pixel (ready/result immediate): SLIDE 3 + ISSUE 1 + WAIT_RES 1 + WRITE 1 = 6 cycles; row start 12.
- `finish` rises the cycle after the last `lbp_valid`.
- Reset mid-frame: immediate return to IDLE; outputs to reset values; next frame restarts from y=1,x=1.

## Test plan
- Reset with `gray_ready`=0 -> all outputs 0, no `gray_req`; raise `gray_ready` -> first `gray_req` next cycle.
- First window: reads 0,128,256,1,129,257,2,130,258 on consecutive cycles -> `win_valid` with `win_addr`=129, `win_pix` k=4 = mem[129]; `res_data`=0x5A -> `lbp_addr`=129, `lbp_data`=0x5A.
- Slide: after pixel 129, reads 3,131,259 only -> `win_addr`=130; `win_pix` k=0 = mem[1].
- Row wrap: after `lbp_addr`=254, FILL reads start at 128 -> `win_addr`=257.
- Stalls: drop `gray_ready` 4 cycles mid-FILL -> `gray_addr` held, no skipped/duplicate read; hold `win_ready`=0 5 cycles -> window stable; `res_valid` pulsed in ISSUE -> ignored.
- Full frame with model datapath: exactly 15876 `lbp_valid` pulses, last `lbp_addr`=16254, `finish`=1 next cycle; result memory matches golden. Reset mid-frame then rerun -> same result.
